// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Holds the FSM state encoding, the default address map and the
// fetch-address legality helper.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0040_0000;
  localparam logic [XLEN-1:0] DEF_MEM_LO   = 32'h0040_0000;
  localparam logic [XLEN-1:0] DEF_MEM_HI   = 32'h0040_0400;
  localparam logic [XLEN-1:0] INSTR_BYTES  = 32'd4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  // A fetch address is usable when it is word aligned and inside [lo, hi].
  function automatic logic pc_legal(input logic [XLEN-1:0] pc,
                                    input logic [XLEN-1:0] lo,
                                    input logic [XLEN-1:0] hi);
    return (pc >= lo) && (pc <= hi) && (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports: clk, reset (async, active high), inc (count one), clear (sync
// zero, wins over inc), count (registered value, sticks at all-ones).
module sat_counter
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one fetch at a time to instruction
// memory, parks the returned word for decode, follows redirects and stops
// on an illegal fetch address.
// Ports:
//   clk, reset                         clock, async active-high reset
//   mem_req_valid/ready, mem_req_addr  fetch request handshake
//   mem_rsp_valid, mem_rsp_data        one-cycle response per request
//   instr_valid/ready, instr_data/pc   instruction offered to decode
//   redirect_valid, redirect_pc        taken branch / jump target
//   halted, fault                      stopped, and stopped on bad PC
//   instruction_count                  saturating delivered-instruction count
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] MEM_LO   = DEF_MEM_LO,
  parameter logic [31:0] MEM_HI   = DEF_MEM_HI
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instruction_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic         mem_req_valid_q, mem_req_valid_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instr_data_q, instr_data_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         halted_q, halted_d;
  logic         fault_q, fault_d;

  logic         count_inc;
  logic         enter_req;
  logic [31:0]  enter_pc;
  logic [31:0]  seq_pc;

  assign seq_pc = pc_q + INSTR_BYTES;

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    drop_d          = drop_q;
    mem_req_valid_d = 1'b0;
    instr_valid_d   = 1'b0;
    instr_data_d    = instr_data_q;
    instr_pc_d      = instr_pc_q;
    halted_d        = halted_q;
    fault_d         = fault_q;
    count_inc       = 1'b0;
    enter_req       = 1'b0;
    enter_pc        = pc_q;

    unique case (state_q)
      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (mem_req_valid_q && mem_req_ready) begin
            // Old-address request already accepted: swallow its response.
            state_d = WAIT;
            drop_d  = 1'b1;
          end else begin
            enter_req = 1'b1;
            enter_pc  = redirect_pc;
          end
        end else if (mem_req_valid_q && mem_req_ready) begin
          state_d = WAIT;
        end else begin
          // Keep requesting; also the first issue right after reset.
          enter_req = 1'b1;
          enter_pc  = pc_q;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (mem_rsp_valid) begin
            drop_d    = 1'b0;
            enter_req = 1'b1;
            enter_pc  = redirect_pc;
          end else begin
            drop_d = 1'b1;
          end
        end else if (mem_rsp_valid) begin
          if (drop_q) begin
            drop_d    = 1'b0;
            enter_req = 1'b1;
            enter_pc  = pc_q;
          end else begin
            state_d       = HOLD;
            instr_valid_d = 1'b1;
            instr_data_d  = mem_rsp_data;
            instr_pc_d    = pc_q;
          end
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          enter_req = 1'b1;
          enter_pc  = redirect_pc;
        end else if (instr_ready) begin
          pc_d      = seq_pc;
          count_inc = 1'b1;
          enter_req = 1'b1;
          enter_pc  = seq_pc;
        end else begin
          instr_valid_d = 1'b1;
        end
      end

      HALT: begin
      end
    endcase

    // Every arrival in REQ re-validates the address before a request goes out.
    if (enter_req) begin
      if (pc_legal(enter_pc, MEM_LO, MEM_HI)) begin
        state_d         = REQ;
        mem_req_valid_d = 1'b1;
      end else begin
        state_d  = HALT;
        halted_d = 1'b1;
        fault_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= REQ;
      pc_q            <= RESET_PC;
      drop_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      instr_valid_q   <= 1'b0;
      instr_data_q    <= '0;
      instr_pc_q      <= '0;
      halted_q        <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      drop_q          <= drop_d;
      mem_req_valid_q <= mem_req_valid_d;
      instr_valid_q   <= instr_valid_d;
      instr_data_q    <= instr_data_d;
      instr_pc_q      <= instr_pc_d;
      halted_q        <= halted_d;
      fault_q         <= fault_d;
    end
  end

  sat_counter #(
    .WIDTH(XLEN)
  ) u_insn_count (
    .clk  (clk),
    .reset(reset),
    .inc  (count_inc),
    .clear(1'b0),
    .count(instruction_count)
  );

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = pc_q;
  assign instr_valid   = instr_valid_q;
  assign instr_data    = instr_data_q;
  assign instr_pc      = instr_pc_q;
  assign halted        = halted_q;
  assign fault         = fault_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, byte address of the first fetch after reset.
REQ-002 Parameter MEM_LO, default 32'h0040_0000, lowest legal fetch byte address.
REQ-003 Parameter MEM_HI, default 32'h0040_0400, highest legal fetch byte address, inclusive.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mem_req_valid  out  1  fetch request to instruction memory; mem_req_addr  out  32  byte address of the request.
REQ-007 mem_req_ready  in  1  memory accepts the request this cycle.
REQ-008 mem_rsp_valid  in  1  response valid, one cycle, exactly one per accepted request; mem_rsp_data  in  32  instruction word.
REQ-009 instr_valid  out  1  instruction offered to decode; instr_data  out  32  the word; instr_pc  out  32  its address.
REQ-010 instr_ready  in  1  decode consumes the offered instruction.
REQ-011 redirect_valid  in  1  branch/jump taken; redirect_pc  in  32  new fetch address.
REQ-012 halted  out  1  sequencer stopped; fault  out  1  stop caused by illegal PC.
REQ-013 instruction_count  out  32  instructions delivered to decode.

Function
REQ-014 FSM states SHALL be REQ, WAIT, HOLD, HALT; reset state is REQ.
REQ-015 REQ: mem_req_valid=1, mem_req_addr=pc; on mem_req_ready, go to WAIT.
REQ-016 On entering REQ, pc<MEM_LO, pc>MEM_HI or pc[1:0]!=0 SHALL go to HALT instead; no request issued, fault=1.
REQ-017 WAIT: on mem_rsp_valid, register data into instr_data and pc into instr_pc, go to HOLD.
REQ-018 HOLD: instr_valid=1; on instr_ready, pc<=pc+4 (mod 2^32), instruction_count+1, go to REQ.
REQ-019 Handshake: a transfer occurs only when valid and ready are both high in the same cycle; outputs stay stable while valid is high and ready is low.
REQ-020 Redirect in REQ: pc<=redirect_pc; if mem_req_ready same cycle, request counts as accepted, go to WAIT with drop flag set; otherwise stay REQ.
REQ-021 Redirect in WAIT: pc<=redirect_pc, drop flag set; the pending response is discarded on arrival, then go to REQ.
REQ-022 Redirect in HOLD overrides instr_ready: instruction dropped, no count, pc<=redirect_pc, go to REQ.
REQ-023 Redirect in HALT SHALL be ignored; HALT exits only by reset.
REQ-024 A response with drop flag set clears the flag and SHALL never reach instr_valid.
REQ-025 instruction_count SHALL saturate at 32'hFFFF_FFFF.
REQ-026 Zero-latency memory gives one instruction per 3 cycles (REQ, WAIT, HOLD).

Reset
REQ-027 Reset SHALL force: state=REQ, pc=RESET_PC, drop flag=0, mem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0, halted=0, fault=0, instruction_count=0.
REQ-028 First request SHALL be issued the first edge after reset deasserts; reset mid-WAIT abandons the in-flight response, and any response arriving during or after reset before a new request is ignored.

Structure
REQ-029 Package fetch_pkg SHALL hold the state enumeration and RESET_PC/MEM_LO/MEM_HI defaults.
REQ-030 Saturating counter SHALL be sub-module sat_counter (width 32, inc, clear).

Verification
REQ-031 Reset release, memory ready=1, rsp 1 cycle later, instr_ready=1 -> addresses 0x00400000, 0x00400004, 0x00400008; count=3 after third handshake.
REQ-032 instr_ready low 5 cycles in HOLD -> instr_valid, instr_data, instr_pc stable; count unchanged; single increment on release.
REQ-033 redirect_pc=0x00400100 during WAIT -> stale response dropped, next mem_req_addr=0x00400100, count unchanged.
REQ-034 Redirect to 0x00400402 -> HALT, fault=1, no further mem_req_valid; later redirect ignored.
REQ-035 Redirect to 0x00400404 -> halted=1, fault=1; reset -> halted=0, pc restarts at 0x00400000.
REQ-036 Count preloaded by forcing to 0xFFFFFFFE, two deliveries -> 0xFFFFFFFF, stays.
